// File: rtl/postfix_pkg.sv
// Shared constants, state encoding and helpers for the postfix evaluator front end.
package postfix_pkg;

   localparam int unsigned TOK_W = 5;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_MUL = 4'h4;

   localparam logic [2:0] ERR_UNDERFLOW = 3'd0;
   localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
   localparam logic [2:0] ERR_BAD_OP    = 3'd2;
   localparam logic [2:0] ERR_LENGTH    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StPrep,
      StIssue,
      StWait,
      StDone
   } sched_state_e;

   function automatic logic is_valid_op(input logic [3:0] code);
      return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
   endfunction

endpackage

// File: rtl/postfix_tok_buf.sv
// Token buffer: sequential write at the fill count, sequential read from a replay pointer.
module postfix_tok_buf
   import postfix_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_clr,
   input  logic             i_wr,
   input  logic [TOK_W-1:0] i_wr_data,
   input  logic             i_rd_next,
   output logic [TOK_W-1:0] o_rd_data,
   output logic [CW-1:0]    o_count
);

   logic [TOK_W-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    r_rd_ptr;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mem    <= '{default: '0};
         r_count  <= '0;
         r_rd_ptr <= '0;
      end else if (i_clr) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr) begin
            r_mem[r_count[AW-1:0]] <= i_wr_data;
            r_count                <= r_count + CW'(1);
         end
         if (i_rd_next) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/postfix_sched.sv
// Postfix front-end controller: validates and buffers one expression, replays it into the
// evaluator, and returns the evaluator result or an error code to the host.
module postfix_sched
   import postfix_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned STACK_MAX = 10,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [4:0]  S_TOKEN,
   input  logic        S_LAST,
   output logic        E_RESET,
   output logic        E_IN_VALID,
   output logic        E_OP_MODE,
   output logic [3:0]  E_IN,
   input  logic [15:0] E_OUT,
   input  logic        E_OUT_VALID,
   output logic [15:0] RESULT,
   output logic        RESULT_VALID,
   output logic        ERR,
   output logic [2:0]  ERR_CODE,
   output logic        BUSY
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STACK_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] L_TMAX = TW'(TIMEOUT - 1);

   sched_state_e     r_state;
   logic [SW-1:0]    r_depth;
   logic             r_op_seen;
   logic [2:0]       r_pend_code;
   logic [CW-1:0]    r_issue;
   logic [TW-1:0]    r_timer;
   logic             r_e_reset;
   logic             r_e_in_valid;
   logic             r_e_op_mode;
   logic [3:0]       r_e_in;
   logic [15:0]      r_result;
   logic             r_result_valid;
   logic             r_err;
   logic [2:0]       r_err_code;

   logic             w_accept;
   logic             w_is_op;
   logic [3:0]       w_code;
   logic [SW-1:0]    w_depth_nxt;
   logic             w_op_seen_nxt;
   logic             w_chk_err;
   logic [2:0]       w_chk_code;
   logic             w_wr;
   logic             w_clr;
   logic             w_rd_next;
   logic             w_timeout;
   logic [TOK_W-1:0] w_rd_data;
   logic [CW-1:0]    w_cnt;

   assign S_READY       = (r_state == StIdle) || (r_state == StDrain);
   assign BUSY          = (r_state != StIdle);
   assign w_accept      = S_VALID && S_READY;
   assign w_is_op       = S_TOKEN[4];
   assign w_code        = S_TOKEN[3:0];
   assign w_depth_nxt   = w_is_op ? (r_depth - SW'(1)) : (r_depth + SW'(1));
   assign w_op_seen_nxt = r_op_seen || w_is_op;
   assign w_timeout     = (r_state == StWait) && !E_OUT_VALID && (r_timer == L_TMAX);

   // Checks are ordered so the highest-priority failure wins.
   always_comb begin
      w_chk_err  = 1'b1;
      w_chk_code = ERR_LENGTH;
      if (w_is_op && !is_valid_op(w_code)) begin
         w_chk_code = ERR_BAD_OP;
      end else if (w_is_op && (r_depth < SW'(2))) begin
         w_chk_code = ERR_UNDERFLOW;
      end else if (!w_is_op && (r_depth == SW'(STACK_MAX))) begin
         w_chk_code = ERR_OVERFLOW;
      end else if (w_cnt == CW'(DEPTH)) begin
         w_chk_code = ERR_LENGTH;
      end else begin
         w_chk_err = 1'b0;
      end
   end

   // Buffer is emptied on every path that returns the FSM to idle.
   always_comb begin
      w_wr      = (r_state == StIdle) && w_accept && !w_chk_err;
      w_rd_next = (r_state == StPrep) || ((r_state == StIssue) && (r_issue != w_cnt));
      w_clr     = 1'b0;
      if (r_state == StDone || w_timeout) begin
         w_clr = 1'b1;
      end else if ((r_state == StDrain) && w_accept && S_LAST) begin
         w_clr = 1'b1;
      end else if ((r_state == StIdle) && w_accept && S_LAST &&
                   (w_chk_err || (w_depth_nxt != SW'(1)))) begin
         w_clr = 1'b1;
      end
   end

   postfix_tok_buf #(
      .DEPTH (DEPTH)
   ) u_tok_buf (
      .CLK       (CLK),
      .RESET     (RESET),
      .i_clr     (w_clr),
      .i_wr      (w_wr),
      .i_wr_data (S_TOKEN),
      .i_rd_next (w_rd_next),
      .o_rd_data (w_rd_data),
      .o_count   (w_cnt)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state        <= StIdle;
         r_depth        <= '0;
         r_op_seen      <= 1'b0;
         r_pend_code    <= '0;
         r_issue        <= '0;
         r_timer        <= '0;
         r_e_reset      <= 1'b0;
         r_e_in_valid   <= 1'b0;
         r_e_op_mode    <= 1'b0;
         r_e_in         <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
         r_err_code     <= '0;
      end else begin
         r_e_reset      <= 1'b0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  if (S_LAST || w_chk_err) begin
                     r_depth   <= '0;
                     r_op_seen <= 1'b0;
                  end else begin
                     r_depth   <= w_depth_nxt;
                     r_op_seen <= w_op_seen_nxt;
                  end
                  if (w_chk_err) begin
                     if (S_LAST) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_chk_code;
                     end else begin
                        r_pend_code <= w_chk_code;
                        r_state     <= StDrain;
                     end
                  end else if (S_LAST) begin
                     if (w_depth_nxt != SW'(1)) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_LENGTH;
                     end else if (!w_op_seen_nxt) begin
                        // Lone operand: answer directly without touching the evaluator.
                        r_result       <= {12'b0, w_code};
                        r_result_valid <= 1'b1;
                        r_state        <= StDone;
                     end else begin
                        r_e_reset <= 1'b1;
                        r_state   <= StPrep;
                     end
                  end
               end
            end
            StDrain: begin
               if (w_accept && S_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= r_pend_code;
                  r_state    <= StIdle;
               end
            end
            StPrep: begin
               r_e_in_valid <= 1'b1;
               r_e_op_mode  <= w_rd_data[4];
               r_e_in       <= w_rd_data[3:0];
               r_issue      <= CW'(1);
               r_state      <= StIssue;
            end
            StIssue: begin
               if (r_issue == w_cnt) begin
                  r_e_in_valid <= 1'b0;
                  r_e_op_mode  <= 1'b0;
                  r_e_in       <= '0;
                  r_timer      <= '0;
                  r_state      <= StWait;
               end else begin
                  r_e_op_mode <= w_rd_data[4];
                  r_e_in      <= w_rd_data[3:0];
                  r_issue     <= r_issue + CW'(1);
               end
            end
            StWait: begin
               if (E_OUT_VALID) begin
                  r_result       <= E_OUT;
                  r_result_valid <= 1'b1;
                  r_state        <= StDone;
               end else if (r_timer == L_TMAX) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
                  r_state    <= StIdle;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign E_RESET      = r_e_reset;
   assign E_IN_VALID   = r_e_in_valid;
   assign E_OP_MODE    = r_e_op_mode;
   assign E_IN         = r_e_in;
   assign RESULT       = r_result;
   assign RESULT_VALID = r_result_valid;
   assign ERR          = r_err;
   assign ERR_CODE     = r_err_code;

endmodule

// File: tb/tb_postfix_sched.sv
// Directed bench for postfix_sched with a behavioural stack evaluator on the E_* side.
module tb_postfix_sched;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        S_VALID = 1'b0;
   logic        S_READY;
   logic [4:0]  S_TOKEN = '0;
   logic        S_LAST = 1'b0;
   logic        E_RESET;
   logic        E_IN_VALID;
   logic        E_OP_MODE;
   logic [3:0]  E_IN;
   logic [15:0] E_OUT = '0;
   logic        E_OUT_VALID = 1'b0;
   logic [15:0] RESULT;
   logic        RESULT_VALID;
   logic        ERR;
   logic [2:0]  ERR_CODE;
   logic        BUSY;

   postfix_sched u_dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .S_VALID      (S_VALID),
      .S_READY      (S_READY),
      .S_TOKEN      (S_TOKEN),
      .S_LAST       (S_LAST),
      .E_RESET      (E_RESET),
      .E_IN_VALID   (E_IN_VALID),
      .E_OP_MODE    (E_OP_MODE),
      .E_IN         (E_IN),
      .E_OUT        (E_OUT),
      .E_OUT_VALID  (E_OUT_VALID),
      .RESULT       (RESULT),
      .RESULT_VALID (RESULT_VALID),
      .ERR          (ERR),
      .ERR_CODE     (ERR_CODE),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   int v_vec = 0;
   int v_miss = 0;
   int v_stall = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      v_vec++;
      if (got !== exp) begin
         v_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Evaluator model: samples on the falling edge, answers one cycle after the token burst.
   logic [15:0] m_stk [16];
   int          m_sp = 0;
   logic        m_prev_v = 1'b0;
   logic        m_mute = 1'b0;
   logic [15:0] m_a, m_b, m_r;

   always @(negedge CLK) begin
      E_OUT_VALID = 1'b0;
      if (E_RESET) m_sp = 0;
      if (E_IN_VALID) begin
         if (!E_OP_MODE) begin
            if (m_sp < 16) begin
               m_stk[m_sp] = {12'b0, E_IN};
               m_sp++;
            end
         end else if (m_sp >= 2) begin
            m_a = m_stk[m_sp-2];
            m_b = m_stk[m_sp-1];
            case (E_IN)
               4'h1:    m_r = m_a + m_b;
               4'h2:    m_r = m_a - m_b;
               4'h4:    m_r = m_a * m_b;
               default: m_r = 16'hdead;
            endcase
            m_sp--;
            m_stk[m_sp-1] = m_r;
         end
      end else if (m_prev_v && !m_mute && m_sp > 0) begin
         E_OUT_VALID = 1'b1;
         E_OUT       = m_stk[m_sp-1];
      end
      m_prev_v = E_IN_VALID;
   end

   logic [4:0] q [$];
   int         o_rst_cnt, o_rst_first, o_iv_cnt, o_iv_first, o_rv_cnt, o_rv_first;
   int         o_err_cnt, o_err_first;
   logic [15:0] o_res;
   logic [2:0]  o_err_code;
   logic [4:0]  o_tok [16];

   // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
   task automatic send_tok(input logic [4:0] tok, input logic last);
      int n;
      S_VALID = 1'b1;
      S_TOKEN = tok;
      S_LAST  = last;
      n = 0;
      while (!S_READY && n < 20) begin
         v_stall++;
         n++;
         @(negedge CLK);
      end
      @(negedge CLK);
      S_VALID = 1'b0;
      S_LAST  = 1'b0;
   endtask

   task automatic send_q();
      v_stall = 0;
      for (int i = 0; i < q.size(); i++) send_tok(q[i], i == q.size() - 1);
   endtask

   // Cycle k of the window is k cycles after the S_LAST acceptance.
   task automatic observe(input int ncyc);
      o_rst_cnt = 0; o_rst_first = -1; o_iv_cnt = 0; o_iv_first = -1;
      o_rv_cnt = 0; o_rv_first = -1; o_err_cnt = 0; o_err_first = -1;
      o_res = '0; o_err_code = '0;
      for (int k = 1; k <= ncyc; k++) begin
         if (E_RESET) begin
            if (o_rst_cnt == 0) o_rst_first = k;
            o_rst_cnt++;
         end
         if (E_IN_VALID) begin
            if (o_iv_cnt == 0) o_iv_first = k;
            if (o_iv_cnt < 16) o_tok[o_iv_cnt] = {E_OP_MODE, E_IN};
            o_iv_cnt++;
         end
         if (RESULT_VALID) begin
            if (o_rv_cnt == 0) o_rv_first = k;
            o_res = RESULT;
            o_rv_cnt++;
         end
         if (ERR) begin
            if (o_err_cnt == 0) o_err_first = k;
            o_err_code = ERR_CODE;
            o_err_cnt++;
         end
         @(negedge CLK);
      end
   endtask

   task automatic run_expr();
      send_q();
      observe(24);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      check_eq("rst_ready", S_READY, 1);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_result", RESULT, 0);
      check_eq("rst_errcode", ERR_CODE, 0);
      check_eq("rst_pulses", {E_RESET, E_IN_VALID, RESULT_VALID, ERR}, 0);
      @(negedge CLK);

      // 3 4 + = 7
      q = '{5'h03, 5'h04, 5'h11};
      run_expr();
      check_eq("a_ereset_cyc", o_rst_first, 1);
      check_eq("a_ereset_cnt", o_rst_cnt, 1);
      check_eq("a_iv_first", o_iv_first, 2);
      check_eq("a_iv_cnt", o_iv_cnt, 3);
      check_eq("a_tok0", o_tok[0], 5'h03);
      check_eq("a_tok1", o_tok[1], 5'h04);
      check_eq("a_tok2", o_tok[2], 5'h11);
      check_eq("a_rv_cyc", o_rv_first, 6);
      check_eq("a_rv_cnt", o_rv_cnt, 1);
      check_eq("a_result", o_res, 16'h0007);
      check_eq("a_no_err", o_err_cnt, 0);
      check_eq("a_result_held", RESULT, 16'h0007);

      // 5 2 - 3 * = 9
      q = '{5'h05, 5'h02, 5'h12, 5'h03, 5'h14};
      run_expr();
      check_eq("b_iv_cnt", o_iv_cnt, 5);
      check_eq("b_tok2", o_tok[2], 5'h12);
      check_eq("b_rv_cyc", o_rv_first, 8);
      check_eq("b_result", o_res, 16'd9);

      // 3 + : underflow on last token
      q = '{5'h03, 5'h11};
      run_expr();
      check_eq("c_err_cyc", o_err_first, 1);
      check_eq("c_err_cnt", o_err_cnt, 1);
      check_eq("c_err_code", o_err_code, 3'd0);
      check_eq("c_no_e_activity", o_rst_cnt + o_iv_cnt, 0);

      // Eleven operands then ten adds: overflow at the 11th operand, then drain
      q.delete();
      for (int i = 0; i < 11; i++) q.push_back(5'h01);
      for (int i = 0; i < 10; i++) q.push_back(5'h11);
      run_expr();
      check_eq("d_err_cyc", o_err_first, 1);
      check_eq("d_err_code", o_err_code, 3'd1);
      check_eq("d_no_stall", v_stall, 0);
      check_eq("d_no_e_activity", o_rst_cnt + o_iv_cnt + o_rv_cnt, 0);

      // Bad opcode 3 mid-expression, then drain
      q = '{5'h03, 5'h03, 5'h13, 5'h11};
      run_expr();
      check_eq("e_err_cyc", o_err_first, 1);
      check_eq("e_err_code", o_err_code, 3'd2);
      check_eq("e_no_stall", v_stall, 0);

      // Bad opcode at empty stack: bad opcode outranks underflow
      q = '{5'h13};
      run_expr();
      check_eq("f_err_code", o_err_code, 3'd2);

      // Single operand answered directly
      q = '{5'h09};
      run_expr();
      check_eq("g_rv_cyc", o_rv_first, 1);
      check_eq("g_result", o_res, 16'd9);
      check_eq("g_no_e_activity", o_rst_cnt + o_iv_cnt, 0);
      check_eq("g_busy_after", BUSY, 0);

      // 3 4 with no operator: unbalanced
      q = '{5'h03, 5'h04};
      run_expr();
      check_eq("h_err_cyc", o_err_first, 1);
      check_eq("h_err_code", o_err_code, 3'd3);

      // 15-token expression: 3 + 3*7 = 24
      q.delete();
      q.push_back(5'h03);
      for (int i = 0; i < 7; i++) begin
         q.push_back(5'h03);
         q.push_back(5'h11);
      end
      run_expr();
      check_eq("i_iv_cnt", o_iv_cnt, 15);
      check_eq("i_rv_cyc", o_rv_first, 18);
      check_eq("i_result", o_res, 16'd24);

      // 17 tokens: 17th accepted with buffer full
      q.delete();
      q.push_back(5'h03);
      for (int i = 0; i < 8; i++) begin
         q.push_back(5'h03);
         q.push_back(5'h11);
      end
      run_expr();
      check_eq("j_err_cyc", o_err_first, 1);
      check_eq("j_err_code", o_err_code, 3'd3);

      // Evaluator never answers: timeout TIMEOUT cycles into WAIT (WAIT starts cycle 5)
      m_mute = 1'b1;
      q = '{5'h03, 5'h04, 5'h11};
      run_expr();
      m_mute = 1'b0;
      check_eq("k_err_cyc", o_err_first, 13);
      check_eq("k_err_code", o_err_code, 3'd4);
      check_eq("k_no_rv", o_rv_cnt, 0);
      check_eq("k_errcode_held", ERR_CODE, 3'd4);

      // Reset in the middle of ISSUE
      q = '{5'h05, 5'h02, 5'h12, 5'h03, 5'h14};
      send_q();
      @(negedge CLK);
      @(negedge CLK);
      check_eq("l_iv_before_rst", E_IN_VALID, 1);
      #2;
      RESET = 1'b1;
      #1;
      check_eq("l_iv_async_drop", E_IN_VALID, 0);
      check_eq("l_busy_async", BUSY, 0);
      check_eq("l_result_clr", RESULT, 0);
      check_eq("l_errcode_clr", ERR_CODE, 0);
      @(negedge CLK);
      RESET = 1'b0;
      q = '{5'h03, 5'h04, 5'h11};
      run_expr();
      check_eq("l_after_iv_cnt", o_iv_cnt, 3);
      check_eq("l_after_rv_cyc", o_rv_first, 6);
      check_eq("l_after_result", o_res, 16'h0007);

      $display("== %0d vectors applied, %0d miscompares ==", v_vec, v_miss);
      $finish;
   end

endmodule
